// File: rtl/bn128_pkg.sv
// Shared BN128 field types for the multiexp front end.
//   fe_t           : one 256-bit base-field element (also the scalar width)
//   fe2_t          : Fp2 element, c0 in the low half, c1 in the high half
//   multiexp_hdr_t : host job header, element count in the low 64 bits
package bn128_pkg;

    localparam int FE_BITS = 256;

    typedef logic [FE_BITS-1:0] fe_t;

    typedef struct packed {
        fe_t c1;
        fe_t c0;
    } fe2_t;

    typedef struct packed {
        logic [447:0] reserved;
        logic [63:0]  num_in;
    } multiexp_hdr_t;

    localparam int HDR_BITS = $bits(multiexp_hdr_t);

    // Element count carried by a header beat.
    function automatic logic [63:0] hdr_num(input multiexp_hdr_t hdr);
        return hdr.num_in;
    endfunction

endpackage

// File: rtl/bn128_multiexp_fp2_input_demux_axis_reg_slice.sv
// One-entry output register for a val/rdy/sop/eop/dat stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture in_sop/in_eop/in_dat this cycle
//   in_sop/in_eop/in_dat: beat to capture
//   rdy                 : downstream ready
//   val/sop/eop/dat     : registered beat presented downstream
//   free                : slot can take a new beat this cycle
module axis_reg_slice #(
    parameter int DAT_BITS = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                in_sop,
    input  logic                in_eop,
    input  logic [DAT_BITS-1:0] in_dat,
    input  logic                rdy,
    output logic                val,
    output logic                sop,
    output logic                eop,
    output logic [DAT_BITS-1:0] dat,
    output logic                free
);

    // The held beat leaves in the same cycle a new one arrives.
    assign free = !val || rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= 1'b0;
            sop <= 1'b0;
            eop <= 1'b0;
            dat <= '0;
        end else if (load) begin
            val <= 1'b1;
            sop <= in_sop;
            eop <= in_eop;
            dat <= in_dat;
        end else if (rdy) begin
            val <= 1'b0;
        end
    end

endmodule

// File: rtl/bn128_multiexp_fp2_input_demux.sv
// Splits a host job packet (header + N records of scalar, X, Y) into the
// scalar stream and the Fp2 affine-point stream consumed by the G2 multiexp.
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_host_val/sop/eop/dat, o_host_rdy : host packet input (512-bit beats)
//   o_scl_val/sop/eop/dat, i_scl_rdy   : scalar stream (256-bit)
//   o_pnt_val/sop/eop/dat, i_pnt_rdy   : point stream (512-bit, X then Y)
//   o_num_in, o_num_val            : element count of the current job
//   o_err, i_err_clr               : sticky malformed-packet flag and clear
module bn128_multiexp_fp2_input_demux
    import bn128_pkg::*;
#(
    parameter int HOST_BITS = 512,
    parameter int SCL_BITS  = $bits(fe_t),
    parameter int PNT_BITS  = $bits(fe2_t)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_host_val,
    input  logic                 i_host_sop,
    input  logic                 i_host_eop,
    input  logic [HOST_BITS-1:0] i_host_dat,
    output logic                 o_host_rdy,
    output logic                 o_scl_val,
    output logic                 o_scl_sop,
    output logic                 o_scl_eop,
    output logic [SCL_BITS-1:0]  o_scl_dat,
    input  logic                 i_scl_rdy,
    output logic                 o_pnt_val,
    output logic                 o_pnt_sop,
    output logic                 o_pnt_eop,
    output logic [PNT_BITS-1:0]  o_pnt_dat,
    input  logic                 i_pnt_rdy,
    output logic [63:0]          o_num_in,
    output logic                 o_num_val,
    output logic                 o_err,
    input  logic                 i_err_clr
);

    typedef enum logic [2:0] {
        IDLE,
        SCL,
        PX,
        PY,
        DRAIN
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [63:0]   cnt;
    multiexp_hdr_t hdr;
    logic [63:0]   hdr_n;

    logic scl_free;
    logic pnt_free;
    logic scl_load;
    logic pnt_load;
    logic scl_sop;
    logic scl_eop;
    logic pnt_sop;
    logic pnt_eop;
    logic err_set;
    logic hdr_take;
    logic cnt_inc;
    logic job_done;
    logic first_rec;
    logic last_rec;

    assign hdr       = multiexp_hdr_t'(i_host_dat[HDR_BITS-1:0]);
    assign hdr_n     = hdr_num(hdr);
    assign first_rec = (cnt == 64'd0);
    // o_num_in is never zero while a job is open, so N-1 does not underflow.
    assign last_rec  = (cnt == o_num_in - 64'd1);

    always_comb begin
        next_state = state;
        o_host_rdy = 1'b0;
        scl_load   = 1'b0;
        pnt_load   = 1'b0;
        scl_sop    = 1'b0;
        scl_eop    = 1'b0;
        pnt_sop    = 1'b0;
        pnt_eop    = 1'b0;
        err_set    = 1'b0;
        hdr_take   = 1'b0;
        cnt_inc    = 1'b0;
        job_done   = 1'b0;
        case (state)
            IDLE: begin
                // Wait for the previous job to leave both slots so o_num_in
                // never changes under beats that still belong to it.
                o_host_rdy = !o_scl_val && !o_pnt_val;
                if (i_host_val && o_host_rdy) begin
                    if (i_host_sop && hdr_n != 64'd0 && !i_host_eop) begin
                        hdr_take   = 1'b1;
                        next_state = SCL;
                    end else begin
                        err_set    = 1'b1;
                        next_state = i_host_eop ? IDLE : DRAIN;
                    end
                end
            end
            SCL: begin
                o_host_rdy = scl_free;
                if (i_host_val && o_host_rdy) begin
                    if (i_host_sop) begin
                        err_set    = 1'b1;
                        next_state = DRAIN;
                    end else begin
                        scl_load = 1'b1;
                        scl_sop  = first_rec;
                        scl_eop  = last_rec;
                        if (i_host_eop) begin
                            err_set    = 1'b1;
                            next_state = IDLE;
                        end else begin
                            next_state = PX;
                        end
                    end
                end
            end
            PX: begin
                o_host_rdy = pnt_free;
                if (i_host_val && o_host_rdy) begin
                    if (i_host_sop) begin
                        err_set    = 1'b1;
                        next_state = DRAIN;
                    end else begin
                        pnt_load = 1'b1;
                        pnt_sop  = first_rec;
                        if (i_host_eop) begin
                            err_set    = 1'b1;
                            next_state = IDLE;
                        end else begin
                            next_state = PY;
                        end
                    end
                end
            end
            PY: begin
                o_host_rdy = pnt_free;
                if (i_host_val && o_host_rdy) begin
                    if (i_host_sop) begin
                        err_set    = 1'b1;
                        next_state = DRAIN;
                    end else begin
                        pnt_load = 1'b1;
                        pnt_eop  = last_rec;
                        if (last_rec && i_host_eop) begin
                            job_done   = 1'b1;
                            next_state = IDLE;
                        end else if (!last_rec && !i_host_eop) begin
                            cnt_inc    = 1'b1;
                            next_state = SCL;
                        end else if (last_rec) begin
                            // Missing eop: the rest of the packet is junk.
                            err_set    = 1'b1;
                            next_state = DRAIN;
                        end else begin
                            err_set    = 1'b1;
                            next_state = IDLE;
                        end
                    end
                end
            end
            DRAIN: begin
                o_host_rdy = 1'b1;
                if (i_host_val && i_host_eop) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= 64'd0;
            o_num_in  <= 64'd0;
            o_num_val <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state <= next_state;
            if (hdr_take) begin
                cnt       <= 64'd0;
                o_num_in  <= hdr_n;
                o_num_val <= 1'b1;
            end else if (cnt_inc) begin
                cnt <= cnt + 64'd1;
            end
            if (job_done) begin
                o_num_val <= 1'b0;
            end
            // A new error in the clear cycle must not be lost.
            if (err_set) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
        end
    end

    axis_reg_slice #(
        .DAT_BITS(SCL_BITS)
    ) u_scl_slice (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .load   (scl_load),
        .in_sop (scl_sop),
        .in_eop (scl_eop),
        .in_dat (i_host_dat[SCL_BITS-1:0]),
        .rdy    (i_scl_rdy),
        .val    (o_scl_val),
        .sop    (o_scl_sop),
        .eop    (o_scl_eop),
        .dat    (o_scl_dat),
        .free   (scl_free)
    );

    axis_reg_slice #(
        .DAT_BITS(PNT_BITS)
    ) u_pnt_slice (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .load   (pnt_load),
        .in_sop (pnt_sop),
        .in_eop (pnt_eop),
        .in_dat (i_host_dat[PNT_BITS-1:0]),
        .rdy    (i_pnt_rdy),
        .val    (o_pnt_val),
        .sop    (o_pnt_sop),
        .eop    (o_pnt_eop),
        .dat    (o_pnt_dat),
        .free   (pnt_free)
    );

endmodule

// File: tb/tb_bn128_multiexp_fp2_input_demux.sv
// Scoreboard bench for the multiexp Fp2 input demux: packets are expanded by a
// packet-level reference model into expected scalar/point beats, and monitors
// compare every downstream handshake against those queues.
module tb_bn128_multiexp_fp2_input_demux;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_host_val = 1'b0;
    logic         i_host_sop = 1'b0;
    logic         i_host_eop = 1'b0;
    logic [511:0] i_host_dat = '0;
    logic         o_host_rdy;
    logic         o_scl_val, o_scl_sop, o_scl_eop;
    logic [255:0] o_scl_dat;
    logic         i_scl_rdy = 1'b1;
    logic         o_pnt_val, o_pnt_sop, o_pnt_eop;
    logic [511:0] o_pnt_dat;
    logic         i_pnt_rdy = 1'b1;
    logic [63:0]  o_num_in;
    logic         o_num_val;
    logic         o_err;
    logic         i_err_clr = 1'b0;

    bn128_multiexp_fp2_input_demux dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_host_val(i_host_val), .i_host_sop(i_host_sop), .i_host_eop(i_host_eop),
        .i_host_dat(i_host_dat), .o_host_rdy(o_host_rdy),
        .o_scl_val(o_scl_val), .o_scl_sop(o_scl_sop), .o_scl_eop(o_scl_eop),
        .o_scl_dat(o_scl_dat), .i_scl_rdy(i_scl_rdy),
        .o_pnt_val(o_pnt_val), .o_pnt_sop(o_pnt_sop), .o_pnt_eop(o_pnt_eop),
        .o_pnt_dat(o_pnt_dat), .i_pnt_rdy(i_pnt_rdy),
        .o_num_in(o_num_in), .o_num_val(o_num_val),
        .o_err(o_err), .i_err_clr(i_err_clr)
    );

    always #5 i_clk = ~i_clk;

    typedef logic [513:0] ent_t;   // {sop, eop, dat512}
    ent_t         scl_q[$];
    ent_t         pnt_q[$];
    logic [511:0] pd[$];
    bit           ps[$];
    bit           pe[$];
    logic [63:0]  exp_num = 64'd0;
    bit           exp_err = 1'b0;
    bit           bp_en = 1'b0;
    int           checks = 0;
    int           fails = 0;

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [511:0] r512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Downstream ready generators (change just after the active edge).
    initial forever begin
        @(posedge i_clk);
        #1;
        i_scl_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        i_pnt_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitors: one pop per downstream handshake.
    always @(negedge i_clk) begin : scl_mon
        ent_t e;
        if (i_rst_n && o_scl_val && i_scl_rdy) begin
            if (scl_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL scl_unexpected: got %0h expected no beat", o_scl_dat);
            end else begin
                e = scl_q.pop_front();
                check("scl_beat", {6'd0, o_scl_sop, o_scl_eop, 256'd0, o_scl_dat}, {6'd0, e});
            end
        end
    end

    always @(negedge i_clk) begin : pnt_mon
        ent_t e;
        if (i_rst_n && o_pnt_val && i_pnt_rdy) begin
            if (pnt_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pnt_unexpected: got %0h expected no beat", o_pnt_dat);
            end else begin
                e = pnt_q.pop_front();
                check("pnt_beat", {6'd0, o_pnt_sop, o_pnt_eop, o_pnt_dat}, {6'd0, e});
            end
        end
    end

    // Packet-level reference: walk the beats by record/field position.
    task automatic model_pkt();
        logic [63:0] n;
        int rec, role;
        bit last;
        exp_err = 1'b0;
        n = pd[0][63:0];
        if (!ps[0] || n == 64'd0 || pe[0]) begin
            exp_err = 1'b1;
            return;
        end
        exp_num = n;
        for (int k = 1; k < pd.size(); k++) begin
            if (ps[k]) begin
                exp_err = 1'b1;
                break;
            end
            rec  = (k - 1) / 3;
            role = (k - 1) % 3;
            last = (64'(rec) == n - 64'd1);
            if (role == 0) scl_q.push_back({rec == 0, last, 256'd0, pd[k][255:0]});
            else if (role == 1) pnt_q.push_back({rec == 0, 1'b0, pd[k]});
            else pnt_q.push_back({1'b0, last, pd[k]});
            if (role == 2 && last) begin
                if (!pe[k]) exp_err = 1'b1;
                break;
            end else if (pe[k]) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic build(input int n, input logic [63:0] hdr_n);
        logic [511:0] h;
        pd.delete(); ps.delete(); pe.delete();
        h = r512();
        h[63:0] = hdr_n;
        pd.push_back(h); ps.push_back(1'b1); pe.push_back(1'b0);
        for (int i = 0; i < 3 * n; i++) begin
            pd.push_back(r512()); ps.push_back(1'b0); pe.push_back(1'b0);
        end
        pe[pe.size() - 1] = 1'b1;
    endtask

    task automatic send_pkt();
        for (int k = 0; k < pd.size(); k++) begin
            int t;
            t = 0;
            @(negedge i_clk);
            i_host_val = 1'b1;
            i_host_sop = ps[k];
            i_host_eop = pe[k];
            i_host_dat = pd[k];
            while (!o_host_rdy && t < 2000) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 2000) begin
                checks++;
                fails++;
                $display("FAIL host_rdy_timeout: beat %0d never accepted", k);
                break;
            end
            @(posedge i_clk);
        end
        @(negedge i_clk);
        i_host_val = 1'b0;
        i_host_sop = 1'b0;
        i_host_eop = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((scl_q.size() != 0 || pnt_q.size() != 0 || o_scl_val || o_pnt_val) && t < 3000) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d scalar and %0d point beats outstanding", scl_q.size(), pnt_q.size());
        end
        repeat (2) @(negedge i_clk);
    endtask

    task automatic run_pkt(input string tag);
        model_pkt();
        send_pkt();
        wait_drain();
        check({tag, "_err"}, 520'(o_err), 520'(exp_err));
        check({tag, "_num_in"}, 520'(o_num_in), 520'(exp_num));
        if (exp_err) begin
            @(negedge i_clk);
            i_err_clr = 1'b1;
            @(negedge i_clk);
            i_err_clr = 1'b0;
            check({tag, "_err_clr"}, 520'(o_err), 520'(0));
        end else begin
            check({tag, "_num_val"}, 520'(o_num_val), 520'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] v;
        int n, f, k;

        repeat (3) @(negedge i_clk);
        check("rst_scl_val", 520'(o_scl_val), 520'(0));
        check("rst_pnt_val", 520'(o_pnt_val), 520'(0));
        check("rst_pnt_dat", 520'(o_pnt_dat), 520'(0));
        check("rst_num", 520'({o_num_val, o_num_in}), 520'(0));
        check("rst_err", 520'(o_err), 520'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("idle_host_rdy", 520'(o_host_rdy), 520'(1));

        // N=1 directed record; scalar upper half carries junk to be ignored.
        build(1, 64'd1);
        v = r512();
        v[255:0] = 256'd5;
        pd[1] = v;
        pd[2] = {256'd2, 256'd1};
        pd[3] = {256'd4, 256'd3};
        run_pkt("n1");

        // N=3 under 50% backpressure on both outputs.
        bp_en = 1'b1;
        build(3, 64'd3);
        run_pkt("n3_bp");

        // Early eop on the second record's X, then a clean N=1 job.
        build(3, 64'd3);
        pe[5] = 1'b1;
        while (pd.size() > 6) begin
            void'(pd.pop_back()); void'(ps.pop_back()); void'(pe.pop_back());
        end
        run_pkt("early_eop");
        build(1, 64'd1);
        run_pkt("after_early");

        // N=0 header followed by four beats ending in eop.
        build(1, 64'd0);
        pe[3] = 1'b0;
        pd.push_back(r512()); ps.push_back(1'b0); pe.push_back(1'b1);
        run_pkt("n0");

        // Missing eop on the last Y plus one trailing beat.
        build(2, 64'd2);
        pe[6] = 1'b0;
        pd.push_back(r512()); ps.push_back(1'b0); pe.push_back(1'b1);
        run_pkt("extra_beat");

        // Stray sop on the first X.
        build(2, 64'd2);
        ps[2] = 1'b1;
        run_pkt("mid_sop");

        // Asynchronous reset right after the X beat of the first record.
        bp_en = 1'b0;
        build(2, 64'd2);
        while (pd.size() > 3) begin
            void'(pd.pop_back()); void'(ps.pop_back()); void'(pe.pop_back());
        end
        model_pkt();
        send_pkt();
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_vals", 520'({o_scl_val, o_pnt_val, o_num_val}), 520'(0));
        check("arst_num_in", 520'(o_num_in), 520'(0));
        scl_q.delete();
        pnt_q.delete();
        exp_num = 64'd0;
        #10;
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        build(2, 64'd2);
        run_pkt("after_rst");

        // Randomised jobs with optional faults under backpressure.
        bp_en = 1'b1;
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(1, 4);
            build(n, 64'(n));
            f = $urandom_range(0, 3);
            if (f == 1) begin
                k = $urandom_range(1, pd.size() - 2);
                pe[k] = 1'b1;
                while (pd.size() > k + 1) begin
                    void'(pd.pop_back()); void'(ps.pop_back()); void'(pe.pop_back());
                end
            end else if (f == 2) begin
                k = $urandom_range(1, pd.size() - 2);
                ps[k] = 1'b1;
            end else if (f == 3) begin
                pe[pd.size() - 1] = 1'b0;
                pd.push_back(r512()); ps.push_back(1'b0); pe.push_back(1'b1);
            end
            run_pkt("rand");
        end

        check("left_scl", 520'(scl_q.size()), 520'(0));
        check("left_pnt", 520'(pnt_q.size()), 520'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
